seq_mult_param: RTL and testbench

SEQ_MULT_PARAM -- requirements
Module: seq_mult_param

---
 rtl/seq_mult_param_pkg.sv | 17 +
 rtl/seq_mult_param_if.sv | 30 +++
 rtl/seq_mult_param_cond_neg.sv | 17 +
 rtl/seq_mult_param.sv | 131 +++++++++++++
 tb/tb_seq_mult_param.sv | 236 +++++++++++++++++++++++
 5 files changed

// File: rtl/seq_mult_param_pkg.sv
// ----------------------------------------------------------------------------
// mult_pkg: definitions shared by the sequential multiplier, its bus
// interface and the bench.
//   W_DEF   - default operand width in bits
//   state_t - multiplier control states
// ----------------------------------------------------------------------------
package mult_pkg;

  localparam int W_DEF = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    FIX  = 2'd2
  } state_t;

endpackage

// File: rtl/seq_mult_param_if.sv
// ----------------------------------------------------------------------------
// seq_mult_if: request/result bundle of the sequential multiplier.
//   start, sgn, a, b : request side, driven by the master
//   p, busy, done    : result side, driven by the multiplier (slave)
// ----------------------------------------------------------------------------
interface seq_mult_if
  import mult_pkg::*;
#(
  parameter int W = W_DEF
);

  logic           start;
  logic           sgn;
  logic [W-1:0]   a;
  logic [W-1:0]   b;
  logic [2*W-1:0] p;
  logic           busy;
  logic           done;

  modport master (
    output start, sgn, a, b,
    input  p, busy, done
  );

  modport slave (
    input  start, sgn, a, b,
    output p, busy, done
  );

endinterface

// File: rtl/seq_mult_param_cond_neg.sv
// ----------------------------------------------------------------------------
// cond_neg: conditional two's-complement negate of an N-bit vector.
//   neg  : 1 = output the negation of din, 0 = pass din through
//   din  : N-bit input
//   dout : N-bit result (wraps modulo 2^N)
// ----------------------------------------------------------------------------
module cond_neg #(
  parameter int N = 8
) (
  input  logic         neg,
  input  logic [N-1:0] din,
  output logic [N-1:0] dout
);

  assign dout = neg ? -din : din;

endmodule

// File: rtl/seq_mult_param.sv
// ----------------------------------------------------------------------------
// seq_mult_param: W x W shift-and-add multiplier, signed or unsigned.
// Operands are reduced to magnitudes, multiplied over exactly W RUN cycles,
// and the sign is applied in a single FIX cycle. One result per W+2 cycles.
//   clk  : clock, rising edge
//   rst  : asynchronous active-high reset
//   bus  : seq_mult_if slave
//          start/sgn/a/b sampled in IDLE; p holds the last result,
//          busy is high outside IDLE, done pulses one cycle when p updates.
// ----------------------------------------------------------------------------
module seq_mult_param
  import mult_pkg::*;
#(
  parameter int W = W_DEF
) (
  input  logic     clk,
  input  logic     rst,
  seq_mult_if.slave bus
);

  localparam int CW = $clog2(W + 1);

  state_t         state_q, state_d;
  logic [W:0]     x_q, x_d;
  logic [2*W:0]   y_q, y_d;
  logic           neg_q, neg_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic [2*W-1:0] p_q, p_d;
  logic           busy_q, busy_d;
  logic           done_q, done_d;

  // Operands are widened by one bit before negation so that the magnitude of
  // -2^(W-1) is representable. The extension bit equals the negate flag:
  // it is 1 only for a signed operand with its MSB set.
  logic           neg_a, neg_b;
  logic [W:0]     a_mag, b_mag;
  logic [2*W-1:0] p_fix;
  logic [W:0]     acc_sum;

  assign neg_a = bus.sgn & bus.a[W-1];
  assign neg_b = bus.sgn & bus.b[W-1];

  cond_neg #(.N(W + 1)) u_neg_a (
    .neg  (neg_a),
    .din  ({neg_a, bus.a}),
    .dout (a_mag)
  );

  cond_neg #(.N(W + 1)) u_neg_b (
    .neg  (neg_b),
    .din  ({neg_b, bus.b}),
    .dout (b_mag)
  );

  cond_neg #(.N(2 * W)) u_neg_p (
    .neg  (neg_q),
    .din  (y_q[2*W-1:0]),
    .dout (p_fix)
  );

  // Upper W+1 bits of the accumulator plus x. Magnitudes never exceed
  // 2^(W-1) for signed or 2^W-1 for unsigned, so the sum fits in W+1 bits
  // and the carry is kept in the top accumulator bit.
  assign acc_sum = y_q[2*W:W] + (y_q[0] ? x_q : '0);

  always_comb begin
    state_d = state_q;
    x_d     = x_q;
    y_d     = y_q;
    neg_d   = neg_q;
    cnt_d   = cnt_q;
    p_d     = p_q;
    done_d  = 1'b0;

    case (state_q)
      IDLE: begin
        if (bus.start) begin
          x_d     = a_mag;
          y_d     = {{W{1'b0}}, b_mag};
          neg_d   = bus.sgn & (bus.a[W-1] ^ bus.b[W-1]);
          cnt_d   = CW'(W);
          state_d = RUN;
        end
      end
      RUN: begin
        y_d   = {1'b0, acc_sum, y_q[W-1:1]};
        cnt_d = cnt_q - CW'(1);
        if (cnt_q == CW'(1)) begin
          state_d = FIX;
        end
      end
      FIX: begin
        p_d     = p_fix;
        done_d  = 1'b1;
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      x_q     <= '0;
      y_q     <= '0;
      neg_q   <= 1'b0;
      cnt_q   <= '0;
      p_q     <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      x_q     <= x_d;
      y_q     <= y_d;
      neg_q   <= neg_d;
      cnt_q   <= cnt_d;
      p_q     <= p_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign bus.p    = p_q;
  assign bus.busy = busy_q;
  assign bus.done = done_q;

endmodule

// File: tb/tb_seq_mult_param.sv
// ----------------------------------------------------------------------------
// tb_seq_mult_param: bench for seq_mult_param at W=8 (directed vectors and
// corner sequences), W=4 (exhaustive) and W=16 (random). Expected products
// are queued when an operation is issued and compared whenever done pulses.
// ----------------------------------------------------------------------------
module tb_seq_mult_param;
  import mult_pkg::*;

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  seq_mult_if #(.W(8))  if8  ();
  seq_mult_if #(.W(4))  if4  ();
  seq_mult_if #(.W(16)) if16 ();

  seq_mult_param #(.W(8))  u_dut8  (.clk(clk), .rst(rst), .bus(if8));
  seq_mult_param #(.W(4))  u_dut4  (.clk(clk), .rst(rst), .bus(if4));
  seq_mult_param #(.W(16)) u_dut16 (.clk(clk), .rst(rst), .bus(if16));

  typedef struct {
    logic        sgn;
    logic [7:0]  a;
    logic [7:0]  b;
    logic [15:0] exp_p;
  } vec_t;

  vec_t tbl [12];

  int n_chk  = 0;
  int n_pass = 0;

  logic [31:0] q8  [$];
  logic [31:0] q4  [$];
  logic [31:0] q16 [$];

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, got, exp);
  endtask

  // Reference product computed with 64-bit integer arithmetic.
  function automatic logic [63:0] ref_mul(input int w, input logic s,
                                          input logic [31:0] a, input logic [31:0] b);
    longint sa, sb, pr;
    sa = longint'(a);
    sb = longint'(b);
    if (s && a[w-1]) sa = sa - (longint'(1) << w);
    if (s && b[w-1]) sb = sb - (longint'(1) << w);
    pr = sa * sb;
    return 64'(pr) & ((64'(1) << (2 * w)) - 64'(1));
  endfunction

  task automatic sample();
    if (if8.done) begin
      if (q8.size() == 0) check("sb8_unexpected_done", 64'(if8.p), 64'hDEAD);
      else check("sb8_p", 64'(if8.p), 64'(q8.pop_front()));
    end
    if (if4.done) begin
      if (q4.size() == 0) check("sb4_unexpected_done", 64'(if4.p), 64'hDEAD);
      else check("sb4_p", 64'(if4.p), 64'(q4.pop_front()));
    end
    if (if16.done) begin
      if (q16.size() == 0) check("sb16_unexpected_done", 64'(if16.p), 64'hDEAD);
      else check("sb16_p", 64'(if16.p), 64'(q16.pop_front()));
    end
  endtask

  task automatic cycle();
    @(posedge clk);
    #1;
    sample();
  endtask

  // Follows a W=8 operation whose edge 0 has just passed: busy through
  // edge 8, done exactly after edge 9, done low again after edge 10.
  task automatic wait_done8(input string name);
    for (int k = 1; k <= 10; k++) begin
      cycle();
      if (k == 1) check({name, "_busy_e1"}, 64'(if8.busy), 64'(1));
      if (k == 8) begin
        check({name, "_busy_e8"}, 64'(if8.busy), 64'(1));
        check({name, "_done_e8"}, 64'(if8.done), 64'(0));
      end
      if (k == 9) begin
        check({name, "_done_e9"}, 64'(if8.done), 64'(1));
        check({name, "_busy_e9"}, 64'(if8.busy), 64'(0));
      end
      if (k == 10) check({name, "_done_e10"}, 64'(if8.done), 64'(0));
    end
  endtask

  task automatic run_op8(input string name, input logic s, input logic [7:0] a,
                         input logic [7:0] b, input logic [15:0] exp_p);
    if8.sgn   = s;
    if8.a     = a;
    if8.b     = b;
    if8.start = 1'b1;
    q8.push_back(32'(exp_p));
    cycle();
    // Scramble the request inputs while the operation is in flight.
    if8.start = 1'b0;
    if8.a     = 8'($urandom);
    if8.b     = 8'($urandom);
    if8.sgn   = 1'($urandom);
    wait_done8(name);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached, got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    tbl = '{
      '{1'b0, 8'hFF, 8'hFF, 16'hFE01},
      '{1'b1, 8'h80, 8'h80, 16'h4000},
      '{1'b1, 8'hFD, 8'h05, 16'hFFF1},
      '{1'b0, 8'h00, 8'hAB, 16'h0000},
      '{1'b0, 8'h80, 8'h80, 16'h4000},
      '{1'b1, 8'h7F, 8'h80, 16'hC080},
      '{1'b1, 8'h80, 8'h7F, 16'hC080},
      '{1'b1, 8'hFF, 8'hFF, 16'h0001},
      '{1'b1, 8'h00, 8'h80, 16'h0000},
      '{1'b0, 8'h01, 8'hFF, 16'h00FF},
      '{1'b1, 8'h01, 8'hFF, 16'hFFFF},
      '{1'b0, 8'h0D, 8'h0B, 16'h008F}
    };

    rst = 1'b0;
    if8.start  = 1'b1; if8.sgn  = 1'b0; if8.a  = 8'd5; if8.b  = 8'd9;
    if4.start  = 1'b0; if4.sgn  = 1'b0; if4.a  = '0;   if4.b  = '0;
    if16.start = 1'b0; if16.sgn = 1'b0; if16.a = '0;   if16.b = '0;

    // Reset applied between clock edges must take effect at once.
    #1 rst = 1'b1;
    #1;
    check("rst_p",    64'(if8.p),    64'(0));
    check("rst_busy", 64'(if8.busy), 64'(0));
    check("rst_done", 64'(if8.done), 64'(0));

    // start held high through reset is ignored until reset releases.
    cycle();
    cycle();
    check("rst_hold_busy", 64'(if8.busy), 64'(0));
    rst = 1'b0;
    q8.push_back(32'd45);
    cycle();
    if8.start = 1'b0;
    wait_done8("rst_start_hold");

    for (int i = 0; i < 12; i++) begin
      run_op8($sformatf("tbl%0d", i), tbl[i].sgn, tbl[i].a, tbl[i].b, tbl[i].exp_p);
    end

    // start held during busy: one result, next op accepted at edge 10.
    if8.sgn = 1'b0; if8.a = 8'd6; if8.b = 8'd7; if8.start = 1'b1;
    q8.push_back(32'd42);
    cycle();
    if8.a = 8'd1; if8.b = 8'd1;
    q8.push_back(32'd1);
    for (int k = 1; k <= 8; k++) cycle();
    check("hold_done_e8", 64'(if8.done), 64'(0));
    cycle();
    check("hold_done_e9", 64'(if8.done), 64'(1));
    check("hold_busy_e9", 64'(if8.busy), 64'(0));
    cycle();
    check("hold_busy_e10", 64'(if8.busy), 64'(1));
    check("hold_done_e10", 64'(if8.done), 64'(0));
    if8.start = 1'b0;
    for (int k = 11; k <= 18; k++) cycle();
    check("hold2_done_e18", 64'(if8.done), 64'(0));
    cycle();
    check("hold2_done_e19", 64'(if8.done), 64'(1));
    cycle();

    // Reset mid-operation aborts with no done pulse.
    if8.sgn = 1'b0; if8.a = 8'd200; if8.b = 8'd3; if8.start = 1'b1;
    cycle();
    if8.start = 1'b0;
    for (int k = 1; k <= 4; k++) cycle();
    rst = 1'b1;
    #1;
    check("abort_p",    64'(if8.p),    64'(0));
    check("abort_busy", 64'(if8.busy), 64'(0));
    check("abort_done", 64'(if8.done), 64'(0));
    #1 rst = 1'b0;
    for (int k = 0; k < 12; k++) cycle();
    check("abort_idle_busy", 64'(if8.busy), 64'(0));
    check("abort_keep_p",    64'(if8.p),    64'(0));
    run_op8("after_abort", 1'b0, 8'd12, 8'd12, 16'd144);

    // W=4 exhaustive, both sign modes, back-to-back at W+2 cycles.
    for (int s = 0; s < 2; s++) begin
      for (int a = 0; a < 16; a++) begin
        for (int b = 0; b < 16; b++) begin
          if4.sgn = 1'(s); if4.a = 4'(a); if4.b = 4'(b); if4.start = 1'b1;
          q4.push_back(32'(ref_mul(4, 1'(s), 32'(a), 32'(b))));
          cycle();
          if4.start = 1'b0;
          for (int k = 0; k < 5; k++) cycle();
        end
      end
    end
    cycle();
    check("drain4", 64'(q4.size()), 64'(0));

    // W=16 random with the extreme corners first.
    for (int i = 0; i < 2000; i++) begin
      logic [15:0] ra, rb;
      logic        rs;
      ra = 16'($urandom);
      rb = 16'($urandom);
      rs = 1'(i);
      if (i == 0) begin ra = 16'hFFFF; rb = 16'hFFFF; end
      if (i == 1) begin ra = 16'h8000; rb = 16'h8000; end
      if (i == 2) begin ra = 16'h8000; rb = 16'h7FFF; end
      if (i == 3) begin ra = 16'h0000; rb = 16'hFFFF; end
      if16.sgn = rs; if16.a = ra; if16.b = rb; if16.start = 1'b1;
      q16.push_back(32'(ref_mul(16, rs, 32'(ra), 32'(rb))));
      cycle();
      if16.start = 1'b0;
      for (int k = 0; k < 17; k++) cycle();
    end
    cycle();
    check("drain16", 64'(q16.size()), 64'(0));
    check("drain8",  64'(q8.size()),  64'(0));

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
